// File: rtl/mbldcm_pkg.sv
// Shared types and constants for the BLDC frequency ramp controller and its phase accumulator.
package mbldcm_pkg;

   localparam int cFreqWidthDef = 32;
   localparam int cStepWidthDef = 16;
   localparam logic [2:0] cSectorCount = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      STOP = 2'd3
   } rampState_t;

endpackage

// File: rtl/mbldcm_phase_acc.sv
// Phase accumulator: the frequency word is added every cycle, and each carry-out advances the sector 0..5.
// Latency: one cycle from the accumulator carry to oPhase. Backpressure: none; iHold freezes the accumulator and the sector.
module mbldcm_phase_acc
   import mbldcm_pkg::*;
#(
   parameter int pFreqWidth = cFreqWidthDef
) (
   input  logic                  iClock,
   input  logic                  iReset_n,
   input  logic                  iHold,
   input  logic [pFreqWidth-1:0] iFreq,
   output logic [2:0]            oPhase
);

   logic [pFreqWidth-1:0] accQ;
   logic [pFreqWidth:0]   accSum;

   assign accSum = {1'b0, accQ} + {1'b0, iFreq};

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         accQ   <= '0;
         oPhase <= '0;
      end else if (!iHold) begin
         accQ <= accSum[pFreqWidth-1:0];
         if (accSum[pFreqWidth]) begin
            oPhase <= (oPhase == cSectorCount - 3'd1) ? 3'd0 : oPhase + 3'd1;
         end
      end
   end

endmodule

// File: rtl/mbldcm_ramp_ctrl.sv
// Frequency ramp controller: steps oFreqCurrent toward a latched target on iTick; iStop forces 0 (optional phase: MBLDCM_RAMP_PHASE_EN).
// Latency: outputs are registered, one cycle after the inputs. Backpressure: none; iLatchTarget and iTick are single-cycle strobes.
module mbldcm_ramp_ctrl
   import mbldcm_pkg::*;
#(
   parameter int pFreqWidth = cFreqWidthDef,
   parameter int pStepWidth = cStepWidthDef
) (
   input  logic                  iClock,
   input  logic                  iReset_n,
   input  logic                  iLatchTarget,
   input  logic [pFreqWidth-1:0] iFreqTarget,
   input  logic                  iTick,
   input  logic [pStepWidth-1:0] iStep,
   input  logic                  iStop,
   output logic [pFreqWidth-1:0] oFreqCurrent,
   output logic                  oFreqReflected,
   output logic                  oStop,
   output logic [2:0]            oPhase
);

   localparam int cCmpW = (pFreqWidth > pStepWidth) ? pFreqWidth : pStepWidth;

   rampState_t            stateQ, stateNext;
   logic [pFreqWidth-1:0] targetQ, targetNext;
   logic [pFreqWidth-1:0] currentNext;
   logic                  reflectedNext;
   logic                  stopNext;
   logic [cCmpW-1:0]      stepEff;
   logic [cCmpW-1:0]      diffUp;
   logic [cCmpW-1:0]      diffDown;

   always_comb begin
      targetNext    = iLatchTarget ? iFreqTarget : targetQ;
      currentNext   = oFreqCurrent;
      stateNext     = stateQ;
      stepEff       = (iStep == '0) ? cCmpW'(1) : cCmpW'(iStep);
      diffUp        = cCmpW'(targetQ) - cCmpW'(oFreqCurrent);
      diffDown      = cCmpW'(oFreqCurrent) - cCmpW'(targetQ);
      reflectedNext = 1'b0;
      stopNext      = 1'b0;

      if (iStop) begin
         currentNext = '0;
         stateNext   = STOP;
      end else if (stateQ == STOP) begin
         // Leaving STOP parks in IDLE so direction is judged from 0 against the new target.
         if (iLatchTarget) begin
            stateNext = IDLE;
         end
      end else begin
         // A direction that no longer matches the target waits one cycle for the state to turn.
         if (iTick && stateQ == UP && targetQ > oFreqCurrent) begin
            currentNext = (diffUp <= stepEff) ? targetQ
                                              : pFreqWidth'(cCmpW'(oFreqCurrent) + stepEff);
         end else if (iTick && stateQ == DOWN && targetQ < oFreqCurrent) begin
            currentNext = (diffDown <= stepEff) ? targetQ
                                                : pFreqWidth'(cCmpW'(oFreqCurrent) - stepEff);
         end
         if (targetQ > currentNext) begin
            stateNext = UP;
         end else if (targetQ < currentNext) begin
            stateNext = DOWN;
         end else begin
            stateNext = IDLE;
         end
      end

      reflectedNext = (stateNext == IDLE) && (currentNext == targetNext);
      stopNext      = (stateNext == STOP);
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         stateQ         <= IDLE;
         targetQ        <= '0;
         oFreqCurrent   <= '0;
         oFreqReflected <= 1'b1;
         oStop          <= 1'b0;
      end else begin
         stateQ         <= stateNext;
         targetQ        <= targetNext;
         oFreqCurrent   <= currentNext;
         oFreqReflected <= reflectedNext;
         oStop          <= stopNext;
      end
   end

`ifdef MBLDCM_RAMP_PHASE_EN
   mbldcm_phase_acc #(
      .pFreqWidth (pFreqWidth)
   ) uPhaseAcc (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .iHold    (stateQ == STOP),
      .iFreq    (oFreqCurrent),
      .oPhase   (oPhase)
   );
`else
   assign oPhase = 3'd0;
`endif

endmodule

// File: tb/tb_mbldcm_ramp_ctrl.sv
// Directed bench for mbldcm_ramp_ctrl: table of ramp vectors plus hand sequences for retarget, stop, reset and same-cycle events.
module tb_mbldcm_ramp_ctrl;
   import mbldcm_pkg::*;

   logic        iClock = 1'b0;
   logic        iReset_n = 1'b0;
   logic        iLatchTarget = 1'b0;
   logic [31:0] iFreqTarget = '0;
   logic        iTick = 1'b0;
   logic [15:0] iStep = '0;
   logic        iStop = 1'b0;
   logic [31:0] oFreqCurrent;
   logic        oFreqReflected;
   logic        oStop;
   logic [2:0]  oPhase;

   int nVec  = 0;
   int nMiss = 0;

   always #5 iClock = ~iClock;

   mbldcm_ramp_ctrl #(.pFreqWidth(32), .pStepWidth(16)) dut (
      .iClock         (iClock),
      .iReset_n       (iReset_n),
      .iLatchTarget   (iLatchTarget),
      .iFreqTarget    (iFreqTarget),
      .iTick          (iTick),
      .iStep          (iStep),
      .iStop          (iStop),
      .oFreqCurrent   (oFreqCurrent),
      .oFreqReflected (oFreqReflected),
      .oStop          (oStop),
      .oPhase         (oPhase)
   );

`ifdef MBLDCM_RAMP_PHASE_EN
   logic       p8Latch = 1'b0;
   logic [7:0] p8Target = '0;
   logic       p8Tick = 1'b0;
   logic [7:0] p8Step = '0;
   logic [7:0] p8Cur;
   logic       p8Refl;
   logic       p8Stop;
   logic [2:0] p8Phase;

   mbldcm_ramp_ctrl #(.pFreqWidth(8), .pStepWidth(8)) dut8 (
      .iClock         (iClock),
      .iReset_n       (iReset_n),
      .iLatchTarget   (p8Latch),
      .iFreqTarget    (p8Target),
      .iTick          (p8Tick),
      .iStep          (p8Step),
      .iStop          (1'b0),
      .oFreqCurrent   (p8Cur),
      .oFreqReflected (p8Refl),
      .oStop          (p8Stop),
      .oPhase         (p8Phase)
   );
`endif

   typedef struct {
      logic        latch;
      logic [31:0] tgt;
      logic        tick;
      logic [15:0] step;
      logic [31:0] expCur;
      rampState_t  expState;
      logic        expRefl;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic l, input logic [31:0] t, input logic tk,
                      input logic [15:0] s, input logic st);
      iLatchTarget = l;
      iFreqTarget  = t;
      iTick        = tk;
      iStep        = s;
      iStop        = st;
      @(posedge iClock);
      #1;
   endtask

   task automatic chkAll(input string name, input logic [31:0] cur, input rampState_t st,
                         input logic refl);
      chk({name, " cur"}, oFreqCurrent, cur);
      chk({name, " state"}, 32'(dut.stateQ), 32'(st));
      chk({name, " refl"}, 32'(oFreqReflected), 32'(refl));
      chk({name, " stop"}, 32'(oStop), 32'(st == STOP));
   endtask

   task automatic doReset();
      iReset_n = 1'b0;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chkAll("reset", 0, IDLE, 1'b1);
      chk("reset phase", 32'(oPhase), 0);
      iReset_n = 1'b1;
   endtask

   task automatic rampTo(input logic [31:0] v, input logic [15:0] s);
      int n = 0;
      while (oFreqCurrent != v && n < 40) begin
         cyc(0, 0, 1, s, 0);
         n++;
      end
      chk("ramp reach", oFreqCurrent, v);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'd100, 1'b1, 16'd30, 32'd0,   IDLE, 1'b0};
      vecs[1]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd0,   UP,   1'b0};
      vecs[2]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd30,  UP,   1'b0};
      vecs[3]  = '{1'b0, 32'd0,   1'b0, 16'd30, 32'd30,  UP,   1'b0};
      vecs[4]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd60,  UP,   1'b0};
      vecs[5]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd90,  UP,   1'b0};
      vecs[6]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd100, IDLE, 1'b1};
      vecs[7]  = '{1'b0, 32'd0,   1'b1, 16'd30, 32'd100, IDLE, 1'b1};
      vecs[8]  = '{1'b1, 32'd95,  1'b0, 16'd0,  32'd100, IDLE, 1'b0};
      vecs[9]  = '{1'b0, 32'd0,   1'b0, 16'd0,  32'd100, DOWN, 1'b0};
      vecs[10] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd99,  DOWN, 1'b0};
      vecs[11] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd98,  DOWN, 1'b0};
      vecs[12] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd97,  DOWN, 1'b0};
      vecs[13] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd96,  DOWN, 1'b0};
      vecs[14] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd95,  IDLE, 1'b1};
      vecs[15] = '{1'b0, 32'd0,   1'b1, 16'd0,  32'd95,  IDLE, 1'b1};

      doReset();

      // Ramp up by 30 to 100, then down to 95 with a zero step.
      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].latch, vecs[i].tgt, vecs[i].tick, vecs[i].step, 1'b0);
         chkAll($sformatf("vec%0d", i), vecs[i].expCur, vecs[i].expState, vecs[i].expRefl);
`ifndef MBLDCM_RAMP_PHASE_EN
         chk($sformatf("vec%0d phase", i), 32'(oPhase), 0);
`endif
      end

      // Retarget below the current value mid-ramp.
      doReset();
      cyc(1, 1000, 1, 100, 0);
      rampTo(300, 100);
      cyc(1, 250, 0, 100, 0);
      chkAll("retarget latch", 300, UP, 1'b0);
      cyc(0, 0, 1, 100, 0);
      chkAll("retarget turn", 300, DOWN, 1'b0);
      cyc(0, 0, 1, 100, 0);
      chkAll("retarget land", 250, IDLE, 1'b1);

      // Emergency stop, sticky until a latch arrives.
      doReset();
      cyc(1, 500, 1, 250, 0);
      rampTo(500, 250);
      cyc(0, 0, 1, 250, 1);
      chkAll("stop hit", 0, STOP, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 250, 0);
         chkAll($sformatf("stop hold%0d", i), 0, STOP, 1'b0);
      end
      cyc(1, 40, 1, 100, 0);
      chkAll("stop exit", 0, IDLE, 1'b0);
      cyc(0, 0, 1, 100, 0);
      chkAll("stop resume", 0, UP, 1'b0);
      cyc(0, 0, 1, 100, 0);
      chkAll("stop land", 40, IDLE, 1'b1);

      // Reset in the middle of a ramp leaves nothing behind.
      doReset();
      cyc(1, 1000, 1, 100, 0);
      rampTo(200, 100);
      iReset_n = 1'b0;
      cyc(0, 0, 1, 100, 0);
      chkAll("midreset", 0, IDLE, 1'b1);
      iReset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 100, 0);
         chkAll($sformatf("postreset%0d", i), 0, IDLE, 1'b1);
      end

      // Latch and tick together: the step uses the old target.
      doReset();
      cyc(1, 20, 1, 10, 0);
      rampTo(20, 10);
      cyc(1, 50, 0, 10, 0);
      chkAll("simul pre", 20, IDLE, 1'b0);
      cyc(0, 0, 0, 10, 0);
      chkAll("simul up", 20, UP, 1'b0);
      cyc(1, 80, 1, 10, 0);
      chkAll("simul step", 30, UP, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 0, 1, 10, 0);
         chkAll($sformatf("simul k%0d", k), 32'(30 + 10 * k), (k == 5) ? IDLE : UP, k == 5);
      end

`ifdef MBLDCM_RAMP_PHASE_EN
      // 8-bit word at 64: one carry every 4 cycles.
      doReset();
      p8Latch  = 1'b1;
      p8Target = 8'd64;
      p8Step   = 8'd64;
      p8Tick   = 1'b1;
      @(posedge iClock);
      #1;
      p8Latch = 1'b0;
      begin
         int n = 0;
         while (p8Cur != 8'd64 && n < 10) begin
            @(posedge iClock);
            #1;
            n++;
         end
      end
      chk("p8 reach", 32'(p8Cur), 64);
      chk("p8 phase0", 32'(p8Phase), 0);
      for (int n = 1; n <= 24; n++) begin
         @(posedge iClock);
         #1;
         chk($sformatf("p8 phase n%0d", n), 32'(p8Phase), 32'((n / 4) % 6));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
